// File: rtl/jk_ctrl_pkg.sv
// rtl/jk_ctrl_pkg.sv - shared opcodes, FSM states and defaults for the JK bank controller
//
// Contents:
//   DEFAULT_WIDTH  default number of JK cells in the bank
//   OP_*           3-bit command opcodes (6 and 7 are illegal and execute as HOLD)
//   state_t        controller FSM states
//   exec_jk        per-bit {j,k} drive for a single-cycle command
package jk_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [2:0] OP_HOLD   = 3'd0;
  localparam logic [2:0] OP_SET    = 3'd1;
  localparam logic [2:0] OP_CLEAR  = 3'd2;
  localparam logic [2:0] OP_TOGGLE = 3'd3;
  localparam logic [2:0] OP_LOAD   = 3'd4;
  localparam logic [2:0] OP_COUNT  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_COUNT = 2'd2
  } state_t;

  // Returns {j, k} for one bank bit. HOLD, COUNT (only reaches EXEC with
  // N = 0) and the illegal opcodes all fall into the default J=K=0.
  function automatic logic [1:0] exec_jk(input logic [2:0] op,
                                         input logic       m,
                                         input logic       a);
    logic [1:0] jk;
    case (op)
      OP_SET:    jk = {m, 1'b0};
      OP_CLEAR:  jk = {1'b0, m};
      OP_TOGGLE: jk = {m, m};
      OP_LOAD:   jk = {m & a, m & ~a};
      default:   jk = 2'b00;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jkff_cell.sv
// rtl/jkff_cell.sv - single JK flip-flop built on a D register
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset, clears q
//   j, k   JK inputs (00 hold, 10 set, 01 clear, 11 toggle)
//   q      flip-flop output
module jkff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      q <= (j & ~q) | (~k & q);
    end
  end

endmodule

// File: rtl/jk_bank_ctrl.sv
// rtl/jk_bank_ctrl.sv - command-driven controller for a bank of JK flip-flops
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   cmd_valid  command presented
//   cmd_ready  controller idle and able to accept a command
//   cmd_op     opcode (HOLD/SET/CLEAR/TOGGLE/LOAD/COUNT, 6-7 illegal)
//   cmd_mask   per-bit enable for SET/CLEAR/TOGGLE/LOAD
//   cmd_arg    LOAD data, or cycle count N for COUNT
//   q          bank outputs
//   busy       a command is executing
//   done       one-cycle pulse in the first idle cycle after a command
module jk_bank_ctrl
  import jk_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [WIDTH-1:0] cmd_arg,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] arg_r;
  logic             done_r;
  logic             accept;
  logic             count_last;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;

  assign accept     = cmd_valid & cmd_ready;
  // arg_r doubles as the remaining-increment counter while counting.
  assign count_last = (state == ST_COUNT) && (arg_r == WIDTH'(1));
  assign done       = done_r;

  // State register and captured command.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      done_r <= 1'b0;
      op_r   <= OP_HOLD;
      mask_r <= '0;
      arg_r  <= '0;
    end else begin
      state  <= state_nxt;
      // The cycle after the last active edge is the first one where q is final.
      done_r <= (state == ST_EXEC) || count_last;
      if (accept) begin
        op_r   <= cmd_op;
        mask_r <= cmd_mask;
        arg_r  <= cmd_arg;
      end else if (state == ST_COUNT) begin
        arg_r <= arg_r - WIDTH'(1);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (cmd_op == OP_COUNT && cmd_arg != '0) begin
            state_nxt = ST_COUNT;
          end else begin
            state_nxt = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        state_nxt = ST_IDLE;
      end
      ST_COUNT: begin
        if (count_last) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs and JK drive.
  always_comb begin
    logic carry;
    logic [1:0] jk;
    cmd_ready = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
    j         = '0;
    k         = '0;
    carry     = 1'b1;
    jk        = 2'b00;
    for (int i = 0; i < WIDTH; i++) begin
      case (state)
        ST_EXEC: begin
          jk   = exec_jk(op_r, mask_r[i], arg_r[i]);
          j[i] = jk[1];
          k[i] = jk[0];
        end
        ST_COUNT: begin
          // Ripple-AND of the lower bits: bit i toggles when all below are 1.
          j[i] = carry;
          k[i] = carry;
        end
        default: begin
          j[i] = 1'b0;
          k[i] = 1'b0;
        end
      endcase
      carry = carry & q[i];
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bank
    jkff_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (j[g]),
      .k     (k[g]),
      .q     (q[g])
    );
  end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// tb/tb_jk_bank_ctrl.sv - self-checking bench for jk_bank_ctrl
module tb_jk_bank_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op = 3'd0;
  logic [W-1:0] cmd_mask = '0;
  logic [W-1:0] cmd_arg = '0;
  logic [W-1:0] q;
  logic         busy;
  logic         done;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  logic [W-1:0] sb[$];

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] mask;
    logic [W-1:0] arg;
    logic [W-1:0] exp_q;
    int           exp_busy;
  } vec_t;

  vec_t tbl[11];

  jk_bank_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_mask  (cmd_mask),
    .cmd_arg   (cmd_arg),
    .q         (q),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Scoreboard: every done pulse pops one expected final q.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        chk("done_q", int'(q), int'(sb.pop_front()));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 0, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int n = 0;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_mask  = v.mask;
    cmd_arg   = v.arg;
    sb.push_back(v.exp_q);
    @(negedge clk);
    cmd_valid = 1'b0;
    while (busy && n < 40) begin
      if (cmd_ready) chk("ready_while_busy", 1, 0);
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", n, v.exp_busy);
    chk("done_after_busy", int'(done), 1);
  endtask

  initial begin
    int acc[3];
    logic [W-1:0] cq[2];

    //             op     mask     arg      exp_q    busy
    tbl[0]  = '{3'd1, 4'b0101, 4'b0000, 4'b0101, 1};
    tbl[1]  = '{3'd3, 4'b1111, 4'b0000, 4'b1010, 1};
    tbl[2]  = '{3'd1, 4'b1111, 4'b0000, 4'b1111, 1};
    tbl[3]  = '{3'd4, 4'b0011, 4'b0110, 4'b1110, 1};
    tbl[4]  = '{3'd2, 4'b1001, 4'b0000, 4'b0000, 1};
    tbl[5]  = '{3'd4, 4'b1111, 4'b1011, 4'b1011, 1};
    tbl[6]  = '{3'd6, 4'b1111, 4'b1111, 4'b1011, 1};
    tbl[7]  = '{3'd3, 4'b0110, 4'b0000, 4'b1101, 1};
    tbl[8]  = '{3'd5, 4'b1111, 4'b0000, 4'b1101, 1};
    tbl[9]  = '{3'd5, 4'b0000, 4'b0010, 4'b1111, 2};
    tbl[10] = '{3'd2, 4'b1111, 4'b0000, 4'b0000, 1};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_q", int'(q), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_done", int'(done), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run_vec(tbl[i]);

    // COUNT 3 from 1110: 1111, 0000 (wrap), 0001.
    wait_ready();
    chk("cnt_start_q", int'(q), 4'b1110);
    cmd_valid = 1'b1;
    cmd_op    = 3'd5;
    cmd_mask  = 4'b1010;
    cmd_arg   = 4'd3;
    sb.push_back(4'b0001);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("cnt_busy0", int'(busy), 1);
    chk("cnt_ready0", int'(cmd_ready), 0);
    cq[0] = 4'b1111;
    cq[1] = 4'b0000;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      chk("cnt_step_q", int'(q), int'(cq[s]));
      chk("cnt_busy", int'(busy), 1);
      chk("cnt_ready", int'(cmd_ready), 0);
      chk("cnt_no_done", int'(done), 0);
    end
    @(negedge clk);
    chk("cnt_end_busy", int'(busy), 0);
    chk("cnt_end_done", int'(done), 1);

    for (int i = 4; i < 11; i++) run_vec(tbl[i]);

    // Reset during COUNT 10 after two increments: no done, q cleared.
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = 3'd5;
    cmd_arg   = 4'd10;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_q_before", int'(q), 4'b0010);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_q", int'(q), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(cmd_ready), 1);
    chk("abort_done", int'(done), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_idle_q", int'(q), 0);

    // Back-to-back with cmd_valid held: illegal 7, HOLD, COUNT 0.
    wait_ready();
    cmd_valid = 1'b1;
    cmd_mask  = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      int n = 0;
      while (!cmd_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      cmd_op  = (c == 0) ? 3'd7 : ((c == 1) ? 3'd0 : 3'd5);
      cmd_arg = (c == 0) ? 4'b1111 : 4'b0000;
      sb.push_back(4'b0000);
      acc[c] = cyc;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("b2b_gap1", acc[1] - acc[0], 2);
    chk("b2b_gap2", acc[2] - acc[1], 2);
    repeat (3) @(negedge clk);
    chk("b2b_sb_drained", sb.size(), 0);
    chk("b2b_q", int'(q), 0);

    // Command during reset is ignored, then accepted after release.
    rst_n     = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = 3'd1;
    cmd_mask  = 4'b1111;
    cmd_arg   = 4'b0000;
    @(negedge clk);
    chk("inrst_q", int'(q), 0);
    chk("inrst_busy", int'(busy), 0);
    rst_n = 1'b1;
    sb.push_back(4'b1111);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("post_rst_busy", int'(busy), 1);
    @(negedge clk);
    chk("post_rst_done", int'(done), 1);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
